otter_bus_decoder: RTL and testbench

Parametrised successor to the single-channel OTTER bus: one primary port fans out to N_SEC secondary ports, selected by address decode. Adds what the plain bus lacks: an explicit ack handshake, wait-state support, an access timeout, and error generation for unmapped, misaligned or illegal-size accesses. Sits between the CPU load/store unit and the memory/MMIO secondaries.

---
 rtl/otter_bus_decoder_if.sv | 25 ++
 rtl/otter_bus_decoder.sv | 165 ++++++++++++++++
 tb/tb_otter_bus_decoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_bus_decoder_if.sv
// Primary-side bus of the OTTER decoder: request from the load/store unit,
// one-cycle ack with read data and error flag.
interface otter_bus_decoder_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          p_rd;
   logic          p_wr;
   logic [1:0]    p_size;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata;
   logic [DW-1:0] p_rdata;
   logic          p_ack;
   logic          p_error;

   modport master (
      output p_rd, p_wr, p_size, p_addr, p_wdata,
      input  p_rdata, p_ack, p_error
   );

   modport slave (
      input  p_rd, p_wr, p_size, p_addr, p_wdata,
      output p_rdata, p_ack, p_error
   );
endinterface

// File: rtl/otter_bus_decoder.sv
// Address decoder fanning one primary port out to N_SEC secondaries, with ack
// handshake, wait states, access timeout and illegal-access error responses.
module otter_bus_decoder #(
   parameter int unsigned           AW      = 32,
   parameter int unsigned           DW      = 32,
   parameter int unsigned           N_SEC   = 4,
   parameter logic [N_SEC*AW-1:0]   BASE    = '0,
   parameter logic [N_SEC*AW-1:0]   MASK    = '0,
   parameter int unsigned           TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   otter_bus_decoder_if.slave  p_bus,
   output logic [N_SEC-1:0]    s_rd,
   output logic [N_SEC-1:0]    s_wr,
   output logic [1:0]          s_size,
   output logic [AW-1:0]       s_addr,
   output logic [DW-1:0]       s_wdata,
   input  logic [N_SEC*DW-1:0] s_rdata,
   input  logic [N_SEC-1:0]    s_ack,
   input  logic [N_SEC-1:0]    s_error
);

   localparam int unsigned IW = (N_SEC > 1) ? $clog2(N_SEC) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              error_q, error_d;
   logic [N_SEC-1:0]  s_rd_q, s_rd_d;
   logic [N_SEC-1:0]  s_wr_q, s_wr_d;

   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic              illegal;
   logic [DW-1:0]     sel_rdata;

   // Scan from the top so the lowest matching channel is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(N_SEC) - 1; i >= 0; i--) begin
         if ((p_bus.p_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      illegal = (p_bus.p_rd && p_bus.p_wr) || (p_bus.p_size == 2'd3) || !hit ||
                (p_bus.p_size == 2'd1 && p_bus.p_addr[0]) ||
                (p_bus.p_size == 2'd2 && p_bus.p_addr[1:0] != 2'b00);
   end

   assign sel_rdata = s_rdata[idx_q*DW +: DW];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      error_d = error_q;
      s_rd_d  = s_rd_q;
      s_wr_d  = s_wr_q;
      unique case (state_q)
         StIdle: begin
            if (p_bus.p_rd || p_bus.p_wr) begin
               addr_d  = p_bus.p_addr;
               size_d  = p_bus.p_size;
               wdata_d = p_bus.p_wdata;
               rd_d    = p_bus.p_rd;
               idx_d   = hit_idx;
               cnt_d   = '0;
               rdata_d = '0;
               if (illegal) begin
                  error_d = 1'b1;
                  state_d = StResp;
               end else begin
                  error_d = 1'b0;
                  s_rd_d  = '0;
                  s_wr_d  = '0;
                  if (p_bus.p_rd) s_rd_d[hit_idx] = 1'b1;
                  else            s_wr_d[hit_idx] = 1'b1;
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            if (s_ack[idx_q]) begin
               rdata_d = rd_q ? sel_rdata : '0;
               error_d = s_error[idx_q];
               s_rd_d  = '0;
               s_wr_d  = '0;
               state_d = StResp;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               error_d = 1'b1;
               s_rd_d  = '0;
               s_wr_d  = '0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            // Response registers are cleared so p_rdata/p_error read 0 outside RESP.
            rdata_d = '0;
            error_d = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
         s_rd_q  <= '0;
         s_wr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         s_rd_q  <= s_rd_d;
         s_wr_q  <= s_wr_d;
      end
   end

   assign p_bus.p_ack   = (state_q == StResp);
   assign p_bus.p_rdata = rdata_q;
   assign p_bus.p_error = error_q;
   assign s_rd          = s_rd_q;
   assign s_wr          = s_wr_q;
   assign s_size        = size_q;
   assign s_addr        = addr_q;
   assign s_wdata       = wdata_q;

endmodule

// File: tb/tb_otter_bus_decoder.sv
// Scoreboard bench for otter_bus_decoder: directed requests push expected
// responses; a monitor pops and compares on every p_ack.
module tb_otter_bus_decoder;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;
   // ch0 0x2xxx_xxxx, ch1 0x1100_xxxx, ch2 0x2000_xxxx (overlaps ch0), ch3 0x3xxx_xxxx
   localparam logic [NS*AW-1:0] BASE_P = {32'h3000_0000, 32'h2000_0000, 32'h1100_0000,
                                          32'h2000_0000};
   localparam logic [NS*AW-1:0] MASK_P = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                          32'hF000_0000};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [NS-1:0]    s_rd, s_wr, s_ack, s_error;
   logic [1:0]       s_size;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata;
   logic [NS*DW-1:0] s_rdata;

   otter_bus_decoder_if #(.AW(AW), .DW(DW)) bus ();

   otter_bus_decoder #(
      .AW(AW), .DW(DW), .N_SEC(NS), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .p_bus(bus),
      .s_rd(s_rd), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack), .s_error(s_error)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   exp_t        sb[$];

   int          ack_wait[NS];
   logic [31:0] ch_data[NS];
   logic        ch_err[NS];
   logic [NS-1:0] stray = '0;

   int          stb_cyc;
   logic [NS-1:0] stb_rd, stb_wr;
   logic        stb_bad;
   logic [31:0] exp_addr, exp_wdata;
   logic [1:0]  exp_size;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Secondary model: ack after ack_wait strobe cycles, plus optional stray acks.
   initial begin
      int scnt[NS];
      logic [NS-1:0] ack_v;
      for (int c = 0; c < NS; c++) scnt[c] = 0;
      s_ack = '0;
      s_error = '0;
      s_rdata = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NS; c++) begin
            if (s_rd[c] || s_wr[c]) begin
               ack_v[c] = (scnt[c] == ack_wait[c]);
               scnt[c]++;
            end else begin
               ack_v[c] = 1'b0;
               scnt[c] = 0;
            end
            s_rdata[c*DW +: DW] = ch_data[c];
            s_error[c] = ch_err[c];
         end
         s_ack = ack_v | stray;
      end
   end

   // Strobe observer: counts active cycles and checks the latched bus is held.
   initial forever begin
      @(negedge clk);
      if ((s_rd | s_wr) != '0) begin
         stb_cyc++;
         stb_rd = stb_rd | s_rd;
         stb_wr = stb_wr | s_wr;
         if (s_addr !== exp_addr || s_wdata !== exp_wdata || s_size !== exp_size)
            stb_bad = 1'b1;
      end
   end

   // Response monitor.
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.p_ack) begin
         if (sb.size() == 0) begin
            check("unexpected p_ack", 64'(bus.p_ack), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " p_rdata"}, 64'(bus.p_rdata), 64'(e.rdata));
            check({e.name, " p_error"}, 64'(bus.p_error), 64'(e.err));
            check({e.name, " ack cycle"}, 64'(cyc), 64'(e.cyc));
         end
      end else begin
         check("idle response outputs", {31'd0, bus.p_error, bus.p_rdata}, 64'd0);
      end
   end

   task automatic drop_req();
      bus.p_rd = 1'b0;
      bus.p_wr = 1'b0;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdata_e, input logic err_e, input int delta,
                      input int stb_n, input logic [3:0] rd_pat, input logic [3:0] wr_pat,
                      input string name);
      bit got;
      @(negedge clk);
      stb_cyc = 0;
      stb_rd = '0;
      stb_wr = '0;
      stb_bad = 1'b0;
      exp_addr = addr;
      exp_wdata = wd;
      exp_size = sz;
      sb.push_back('{rdata_e, err_e, cyc + 1 + delta, name});
      bus.p_rd = rd;
      bus.p_wr = wr;
      bus.p_size = sz;
      bus.p_addr = addr;
      bus.p_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (bus.p_ack) got = 1'b1;
      end
      drop_req();
      check({name, " ack seen"}, 64'(got), 64'd1);
      check({name, " strobe cycles"}, 64'(stb_cyc), 64'(stb_n));
      check({name, " strobe pattern"}, {56'd0, stb_rd, stb_wr}, {56'd0, rd_pat, wr_pat});
      check({name, " latched bus stable"}, 64'(stb_bad), 64'd0);
   endtask

   initial begin
      for (int c = 0; c < NS; c++) begin
         ack_wait[c] = 0;
         ch_data[c] = 32'h0;
         ch_err[c] = 1'b0;
      end
      bus.p_rd = 1'b0;
      bus.p_wr = 1'b0;
      bus.p_size = 2'd0;
      bus.p_addr = '0;
      bus.p_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs", {27'd0, bus.p_ack, bus.p_error, s_rd, s_wr, bus.p_rdata},
            64'd0);
      rst_n = 1'b1;

      ch_data[1] = 32'hDEAD_BEEF;
      req(1, 0, 2'd2, 32'h1100_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 1, 4'b0010, 4'b0000,
          "zero-wait read");

      ack_wait[0] = 3;
      ch_data[0] = 32'h5555_AAAA;
      req(0, 1, 2'd2, 32'h2100_0000, 32'h1234_5678, 32'h0, 0, 4, 4, 4'b0000, 4'b0001,
          "wait-state write");

      req(1, 0, 2'd2, 32'hF000_0000, 32'h0, 32'h0, 1, 0, 0, 4'b0, 4'b0, "unmapped");
      req(1, 0, 2'd1, 32'h1100_0001, 32'h0, 32'h0, 1, 0, 0, 4'b0, 4'b0, "misaligned half");
      req(0, 1, 2'd3, 32'h1100_0000, 32'h0, 32'h0, 1, 0, 0, 4'b0, 4'b0, "size 3");
      req(1, 1, 2'd2, 32'h1100_0000, 32'h0, 32'h0, 1, 0, 0, 4'b0, 4'b0, "rd and wr");
      req(1, 0, 2'd2, 32'h1100_0002, 32'h0, 32'h0, 1, 0, 0, 4'b0, 4'b0, "misaligned word");

      ch_data[1] = 32'h0000_00AB;
      req(1, 0, 2'd0, 32'h1100_0003, 32'h0, 32'h0000_00AB, 0, 1, 1, 4'b0010, 4'b0000,
          "byte read odd addr");

      ack_wait[3] = 1000;
      ch_data[3] = 32'h7777_7777;
      req(1, 0, 2'd2, 32'h3000_0004, 32'h0, 32'h0, 1, 16, 16, 4'b1000, 4'b0000, "timeout");

      // Overlap: ch0 wins; a stray ack on unselected ch2 must not end the access early.
      ack_wait[0] = 1;
      ch_data[0] = 32'hCAFE_0000;
      ch_err[0] = 1'b1;
      stray = 4'b0100;
      req(1, 0, 2'd2, 32'h2000_0008, 32'h0, 32'hCAFE_0000, 1, 2, 2, 4'b0001, 4'b0000,
          "overlap error passthrough");
      stray = '0;
      ch_err[0] = 1'b0;

      // Reset during a wait state: strobe must drop without a clock edge, no p_ack.
      @(negedge clk);
      bus.p_rd = 1'b1;
      bus.p_size = 2'd2;
      bus.p_addr = 32'h3000_0000;
      repeat (5) @(negedge clk);
      check("strobe before reset", 64'(s_rd), 64'(4'b1000));
      #2 rst_n = 1'b0;
      #1 check("strobes after async reset", {56'd0, s_rd, s_wr}, 64'd0);
      drop_req();
      repeat (3) @(negedge clk);
      check("no ack during reset", 64'(bus.p_ack), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      ch_data[1] = 32'h0BAD_F00D;
      req(1, 0, 2'd2, 32'h1100_0100, 32'h0, 32'h0BAD_F00D, 0, 1, 1, 4'b0010, 4'b0000,
          "read after reset");

      repeat (4) @(negedge clk);
      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
